// File: rtl/frame_assembler.sv
// Byte-to-frame assembler: shifts received bytes into an assembly register and
// hands completed frames to a separate output register with a valid/ready handshake.
module frame_assembler #(
  parameter int FRAME_BYTES    = 80,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  input  logic                               flush,
  output logic [8*FRAME_BYTES-1:0]           frame_data,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  output logic                               receiving,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
  output logic                               frame_done,
  output logic                               drop_err,
  output logic                               timeout_err
);

  localparam int CW = $clog2(FRAME_BYTES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam int FW = 8*FRAME_BYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, FULL = 2'd2} state_t;

  state_t          state, state_next;
  logic [FW-1:0]   asm_reg, asm_next, shifted;
  logic [FW-1:0]   data_next;
  logic [CW-1:0]   count_next;
  logic [TW-1:0]   timer, timer_next;
  logic            valid_next, done_next, drop_next, tout_next;
  logic            slot_free;

  assign shifted   = {asm_reg[FW-9:0], rx_data};
  assign slot_free = !frame_valid || frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      asm_reg     <= '0;
      byte_count  <= '0;
      timer       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      receiving   <= 1'b0;
      frame_done  <= 1'b0;
      drop_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      asm_reg     <= asm_next;
      byte_count  <= count_next;
      timer       <= timer_next;
      frame_data  <= data_next;
      frame_valid <= valid_next;
      receiving   <= (state_next == RECV);
      frame_done  <= done_next;
      drop_err    <= drop_next;
      timeout_err <= tout_next;
    end
  end

  // A handshake always frees the output slot; flush never touches it.
  always_comb begin
    state_next = state;
    asm_next   = asm_reg;
    count_next = byte_count;
    timer_next = timer;
    data_next  = frame_data;
    valid_next = frame_valid && !frame_ready;
    done_next  = 1'b0;
    drop_next  = 1'b0;
    tout_next  = 1'b0;

    if (flush) begin
      state_next = IDLE;
      count_next = '0;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            asm_next   = shifted;
            count_next = CW'(1);
            timer_next = '0;
            state_next = RECV;
          end
        end
        RECV: begin
          if (rx_valid) begin
            asm_next   = shifted;
            timer_next = '0;
            if (byte_count == CW'(FRAME_BYTES-1)) begin
              if (slot_free) begin
                data_next  = shifted;
                valid_next = 1'b1;
                done_next  = 1'b1;
                count_next = '0;
                state_next = IDLE;
              end else begin
                count_next = CW'(FRAME_BYTES);
                state_next = FULL;
              end
            end else begin
              count_next = byte_count + CW'(1);
            end
          end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
            tout_next  = 1'b1;
            count_next = '0;
            timer_next = '0;
            state_next = IDLE;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        FULL: begin
          drop_next = rx_valid;
          if (slot_free) begin
            data_next  = asm_reg;
            valid_next = 1'b1;
            done_next  = 1'b1;
            count_next = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
          timer_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed test of frame_assembler with 4-byte frames and an 8-cycle idle timeout.
module tb_frame_assembler;

  localparam int FB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        flush;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        receiving;
  logic [2:0]  byte_count;
  logic        frame_done;
  logic        drop_err;
  logic        timeout_err;

  int checks = 0;
  int fails  = 0;

  frame_assembler #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .flush(flush),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .receiving(receiving), .byte_count(byte_count), .frame_done(frame_done),
    .drop_err(drop_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f, input logic r);
    rx_valid    = v;
    rx_data     = d;
    flush       = f;
    frame_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_data"},    frame_data,  0);
    checkOutput({tag, "_valid"},   frame_valid, 0);
    checkOutput({tag, "_count"},   byte_count,  0);
    checkOutput({tag, "_recv"},    receiving,   0);
    checkOutput({tag, "_done"},    frame_done,  0);
    checkOutput({tag, "_drop"},    drop_err,    0);
    checkOutput({tag, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; flush = 1'b0; frame_ready = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with consumer ready
    applyStimulus(1, 8'h11, 0, 1);
    applyStimulus(1, 8'h22, 0, 1);
    applyStimulus(1, 8'h33, 0, 1);
    checkOutput("basic_count3", byte_count, 3);
    checkOutput("basic_recv",   receiving,  1);
    applyStimulus(1, 8'h44, 0, 1);
    checkOutput("basic_data",   frame_data,  32'h11223344);
    checkOutput("basic_valid",  frame_valid, 1);
    checkOutput("basic_done",   frame_done,  1);
    checkOutput("basic_recv0",  receiving,   0);
    checkOutput("basic_count0", byte_count,  0);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("basic_consumed", frame_valid, 0);
    checkOutput("basic_done_pulse", frame_done, 0);

    // Back-pressure: second frame waits in FULL, extra byte is dropped
    for (int i = 0; i < FB; i++) applyStimulus(1, 8'hA1 + 8'(i), 0, 0);
    checkOutput("bp_first_data",  frame_data,  32'hA1A2A3A4);
    checkOutput("bp_first_valid", frame_valid, 1);
    for (int i = 0; i < FB; i++) applyStimulus(1, 8'hB1 + 8'(i), 0, 0);
    checkOutput("bp_full_count", byte_count, 4);
    checkOutput("bp_full_done",  frame_done, 0);
    checkOutput("bp_held_data",  frame_data, 32'hA1A2A3A4);
    applyStimulus(1, 8'hC5, 0, 0);
    checkOutput("bp_drop",       drop_err,   1);
    checkOutput("bp_held_count", byte_count, 4);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("bp_second_data",  frame_data,  32'hB1B2B3B4);
    checkOutput("bp_second_valid", frame_valid, 1);
    checkOutput("bp_second_done",  frame_done,  1);
    checkOutput("bp_drop_pulse",   drop_err,    0);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("bp_consumed", frame_valid, 0);

    // Timeout after two bytes, then a fresh frame
    applyStimulus(1, 8'hAA, 0, 1);
    applyStimulus(1, 8'hBB, 0, 1);
    checkOutput("to_count2", byte_count, 2);
    for (int i = 0; i < TO-1; i++) applyStimulus(0, 8'h00, 0, 1);
    checkOutput("to_not_yet", timeout_err, 0);
    checkOutput("to_still_recv", receiving, 1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("to_pulse", timeout_err, 1);
    checkOutput("to_count0", byte_count, 0);
    checkOutput("to_recv0", receiving, 0);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("to_pulse_end", timeout_err, 0);
    for (int i = 0; i < FB; i++) applyStimulus(1, 8'h01 + 8'(i), 0, 1);
    checkOutput("to_new_data", frame_data, 32'h01020304);
    checkOutput("to_new_valid", frame_valid, 1);
    applyStimulus(0, 8'h00, 0, 1);

    // Byte on the last idle cycle is accepted
    applyStimulus(1, 8'h55, 0, 1);
    for (int i = 0; i < TO-1; i++) applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(1, 8'h66, 0, 1);
    checkOutput("edge_no_timeout", timeout_err, 0);
    checkOutput("edge_count2", byte_count, 2);
    checkOutput("edge_recv", receiving, 1);
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("edge_flush_count", byte_count, 0);

    // Flush together with the third byte
    applyStimulus(1, 8'h77, 0, 1);
    applyStimulus(1, 8'h88, 0, 1);
    applyStimulus(1, 8'h99, 1, 1);
    checkOutput("flush_drop",  drop_err,   0);
    checkOutput("flush_count", byte_count, 0);
    checkOutput("flush_recv",  receiving,  0);
    checkOutput("flush_data",  frame_data, 32'h01020304);
    checkOutput("flush_valid", frame_valid, 0);

    // Asynchronous reset mid-frame
    applyStimulus(1, 8'hD1, 0, 1);
    applyStimulus(1, 8'hD2, 0, 1);
    rst = 1'b1;
    #2;
    checkResetValues("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FB; i++) applyStimulus(1, 8'hE1 + 8'(i), 0, 1);
    checkOutput("midrst_new_data", frame_data, 32'hE1E2E3E4);
    checkOutput("midrst_new_done", frame_done, 1);
    applyStimulus(0, 8'h00, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
